// File: rtl/dsp_seq_pkg.sv
// -----------------------------------------------------------------------------
// dsp_seq_pkg
// Shared types and widths for the DSP48A1 command sequencer.
//   seq_state_t : sequencer FSM states (INIT, RUN, DRAIN)
//   dsp_res_t   : one captured slice result {p, carryout}
// -----------------------------------------------------------------------------
package dsp_seq_pkg;

    localparam int A_W  = 18;   // A/B/D operand width
    localparam int C_W  = 48;   // C operand and P result width
    localparam int OP_W = 8;    // OPMODE width

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [C_W-1:0] p;
        logic           carryout;
    } dsp_res_t;

endpackage

// File: rtl/dsp_seq_fifo.sv
// -----------------------------------------------------------------------------
// dsp_seq_fifo
// Synchronous FIFO with occupancy count. Pointers carry one extra MSB so that
// full and empty are told apart when the index bits are equal. A push into an
// empty FIFO becomes visible on pop_data the following cycle (no bypass).
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push, push_data  write one entry (ignored when full)
//   pop              remove head entry (ignored when empty)
//   pop_data         head entry (undefined while empty)
//   empty            no entries stored
//   count            number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module dsp_seq_fifo #(
    parameter int WIDTH = 49,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count    = wr_ptr - rd_ptr;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only ever
    // read after it has been written, and skipping the reset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/dsp_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// dsp_cmd_sequencer
// Initiator-side driver for a DSP48A1 slice. Commands arriving on a valid/ready
// stream are registered straight onto the slice inputs, a valid bit follows
// each one down a PIPE_LAT-deep shift register, and the slice output is
// captured into a result FIFO when that bit falls out of the end. A credit
// check at accept time guarantees every in-flight result has a FIFO slot, so
// the slice clock enable never has to drop.
//
// Optional build macro: DSP_SEQ_CHECK_EN adds cmd_exp/cmd_chk inputs that ride
// along with each command and a mismatch pulse / saturating err_cnt output.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_opmode, cmd_a/b/d/c,   command fields copied onto the slice inputs
//   cmd_carryin
//   flush / flush_done         drain request (level) / drain complete (pulse)
//   dsp_a/b/d/c, dsp_opmode,   registered slice inputs
//   dsp_carryin
//   dsp_rst, dsp_ce            slice reset (active high) and clock enable
//   dsp_p, dsp_carryout        slice outputs
//   res_valid/res_ready,       result stream, head of the result FIFO
//   res_p, res_carryout
//   busy                       results in flight or waiting in the FIFO
//   cmd_exp, cmd_chk,          (DSP_SEQ_CHECK_EN only) expected-result check
//   mismatch, err_cnt
// -----------------------------------------------------------------------------
module dsp_cmd_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int PIPE_LAT   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int RST_CYC    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_opmode,
    input  logic [A_W-1:0]   cmd_a,
    input  logic [A_W-1:0]   cmd_b,
    input  logic [A_W-1:0]   cmd_d,
    input  logic [C_W-1:0]   cmd_c,
    input  logic             cmd_carryin,
`ifdef DSP_SEQ_CHECK_EN
    input  logic [C_W-1:0]   cmd_exp,
    input  logic             cmd_chk,
    output logic             mismatch,
    output logic [15:0]      err_cnt,
`endif
    input  logic             flush,
    output logic             flush_done,
    output logic [A_W-1:0]   dsp_a,
    output logic [A_W-1:0]   dsp_b,
    output logic [A_W-1:0]   dsp_d,
    output logic [C_W-1:0]   dsp_c,
    output logic [OP_W-1:0]  dsp_opmode,
    output logic             dsp_carryin,
    output logic             dsp_rst,
    output logic             dsp_ce,
    input  logic [C_W-1:0]   dsp_p,
    input  logic             dsp_carryout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [C_W-1:0]   res_p,
    output logic             res_carryout,
    output logic             busy
);

    localparam int IF_W = $clog2(PIPE_LAT + 1);
    localparam int FC_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OS_W = $clog2(FIFO_DEPTH + PIPE_LAT + 1);
    localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    seq_state_t          state;
    logic [RC_W-1:0]     rst_cnt;
    logic                done_sent;      // flush_done already issued for this flush
    logic [PIPE_LAT-1:0] vld;
    logic [IF_W-1:0]     inflight;
    logic [FC_W-1:0]     fifo_count;
    logic                fifo_empty;
    logic [OS_W-1:0]     outstanding;
    dsp_res_t            res_head;
    dsp_res_t            res_in;
    logic                accept;
    logic                capture;
    logic                res_pop;

    assign capture     = vld[PIPE_LAT-1];
    assign outstanding = OS_W'(fifo_count) + OS_W'(inflight);

    // cmd_ready must respond to flush and to the current credit count in the
    // same cycle, otherwise a command could be accepted without a free slot.
    assign cmd_ready = (state == RUN) && !flush && (outstanding < OS_W'(FIFO_DEPTH));
    assign accept    = cmd_valid && cmd_ready;

    assign dsp_ce    = 1'b1;
    assign res_valid = !fifo_empty;
    assign res_pop   = res_valid && res_ready;
    assign busy      = (inflight != '0) || !fifo_empty;

    // The FIFO head is forced to zero while empty so the result bus shows a
    // defined value out of reset without resetting the storage.
    assign res_p        = res_valid ? res_head.p        : '0;
    assign res_carryout = res_valid ? res_head.carryout : 1'b0;

    assign res_in = '{p: dsp_p, carryout: dsp_carryout};

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            rst_cnt    <= '0;
            dsp_rst    <= 1'b1;
            done_sent  <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                INIT: begin
                    if (rst_cnt == RC_W'(RST_CYC - 1)) begin
                        dsp_rst <= 1'b0;
                        state   <= RUN;
                    end else begin
                        rst_cnt <= rst_cnt + RC_W'(1);
                    end
                end
                RUN: begin
                    if (flush) begin
                        done_sent <= 1'b0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!done_sent) begin
                        if (inflight == '0) begin
                            flush_done <= 1'b1;
                            if (flush) begin
                                done_sent <= 1'b1;
                            end else begin
                                state <= RUN;
                            end
                        end
                    end else if (!flush) begin
                        state <= RUN;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    // ----------------------------------------------------- issue and track
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsp_a       <= '0;
            dsp_b       <= '0;
            dsp_d       <= '0;
            dsp_c       <= '0;
            dsp_opmode  <= '0;
            dsp_carryin <= 1'b0;
            vld         <= '0;
            inflight    <= '0;
        end else begin
            if (accept) begin
                dsp_a       <= cmd_a;
                dsp_b       <= cmd_b;
                dsp_d       <= cmd_d;
                dsp_c       <= cmd_c;
                dsp_opmode  <= cmd_opmode;
                dsp_carryin <= cmd_carryin;
            end
            vld      <= (vld << 1) | PIPE_LAT'(accept);
            inflight <= inflight + IF_W'(accept) - IF_W'(capture);
        end
    end

    // ----------------------------------------------------------- result FIFO
    dsp_seq_fifo #(
        .WIDTH ($bits(dsp_res_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (capture),
        .push_data (res_in),
        .pop       (res_pop),
        .pop_data  (res_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef DSP_SEQ_CHECK_EN
    // ------------------------------------------------------ result checker
    // Expected values travel alongside vld; chk_sr marks which of them count.
    logic [C_W-1:0]      exp_sr [PIPE_LAT];
    logic [PIPE_LAT-1:0] chk_sr;
    logic                miss;

    assign miss = capture && chk_sr[PIPE_LAT-1] && (dsp_p != exp_sr[PIPE_LAT-1]);

    // Expected values are only consulted where chk_sr is set, so no reset.
    always_ff @(posedge clk) begin
        exp_sr[0] <= cmd_exp;
        for (int i = 1; i < PIPE_LAT; i++) begin
            exp_sr[i] <= exp_sr[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_sr   <= '0;
            mismatch <= 1'b0;
            err_cnt  <= '0;
        end else begin
            chk_sr   <= (chk_sr << 1) | PIPE_LAT'(accept && cmd_chk);
            mismatch <= miss;
            if (miss && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dsp_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dsp_cmd_sequencer
// Self-checking bench for dsp_cmd_sequencer. A behavioural slice model feeds
// dsp_p/dsp_carryout; a scoreboard queue holds, for every accepted command,
// its arithmetic result and the cycle from which it may appear on res_*.
// Inputs change on the falling edge and outputs are sampled just after it.
// Build with +define+DSP_SEQ_CHECK_EN to also exercise the result checker.
// -----------------------------------------------------------------------------
module tb_dsp_cmd_sequencer;
    import dsp_seq_pkg::*;

    // Depth 8 > PIPE_LAT + 1 lets a back-to-back stream run without credit
    // stalls; RST_CYC = 3 exercises a non-default reset stretch.
    localparam int PIPE_LAT   = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int RST_CYC    = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cmd_valid = 1'b0, cmd_ready;
    logic [7:0]      cmd_opmode = '0;
    logic [17:0]     cmd_a = '0, cmd_b = '0, cmd_d = '0;
    logic [47:0]     cmd_c = '0;
    logic            cmd_carryin = 1'b0;
    logic            flush = 1'b0, flush_done;
    logic [17:0]     dsp_a, dsp_b, dsp_d;
    logic [47:0]     dsp_c, dsp_p;
    logic [7:0]      dsp_opmode;
    logic            dsp_carryin, dsp_rst, dsp_ce, dsp_carryout;
    logic            res_valid, res_ready = 1'b0, res_carryout, busy;
    logic [47:0]     res_p;
`ifdef DSP_SEQ_CHECK_EN
    logic [47:0]     cmd_exp = '0;
    logic            cmd_chk = 1'b0, mismatch;
    logic [15:0]     err_cnt;
`endif

    always #5 clk = ~clk;

    dsp_cmd_sequencer #(
        .PIPE_LAT   (PIPE_LAT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .RST_CYC    (RST_CYC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_opmode   (cmd_opmode),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_d        (cmd_d),
        .cmd_c        (cmd_c),
        .cmd_carryin  (cmd_carryin),
`ifdef DSP_SEQ_CHECK_EN
        .cmd_exp      (cmd_exp),
        .cmd_chk      (cmd_chk),
        .mismatch     (mismatch),
        .err_cnt      (err_cnt),
`endif
        .flush        (flush),
        .flush_done   (flush_done),
        .dsp_a        (dsp_a),
        .dsp_b        (dsp_b),
        .dsp_d        (dsp_d),
        .dsp_c        (dsp_c),
        .dsp_opmode   (dsp_opmode),
        .dsp_carryin  (dsp_carryin),
        .dsp_rst      (dsp_rst),
        .dsp_ce       (dsp_ce),
        .dsp_p        (dsp_p),
        .dsp_carryout (dsp_carryout),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_p        (res_p),
        .res_carryout (res_carryout),
        .busy         (busy)
    );

    // Arithmetic of the slice for the OPMODE subset used here:
    // X = M (optionally pre-added B) or the D:A:B concatenation, Z = 0 or C,
    // P = Z + X + CARRYIN with the 49th bit as CARRYOUT.
    function automatic logic [48:0] slice_fn(input logic [7:0] op, input logic [17:0] a,
                                             input logic [17:0] b, input logic [17:0] d,
                                             input logic [47:0] c, input logic cin);
        logic [17:0]        b1;
        logic signed [35:0] m;
        logic [47:0]        x;
        logic [47:0]        z;
        b1 = op[4] ? (op[6] ? d - b : d + b) : b;
        m  = $signed(a) * $signed(b1);
        case (op[1:0])
            2'd1:    x = {{12{m[35]}}, m};
            2'd3:    x = {d[11:0], a, b};
            default: x = '0;
        endcase
        z = (op[3:2] == 2'd3) ? c : '0;
        return {1'b0, z} + {1'b0, x} + 49'(cin);
    endfunction

    // Slice model: result appears PIPE_LAT-1 edges after the inputs are sampled,
    // which lines it up with the sequencer's capture point.
    logic [48:0] stage [PIPE_LAT-1];
    always @(posedge clk) begin
        if (dsp_rst) begin
            for (int i = 0; i < PIPE_LAT - 1; i++) stage[i] <= '0;
        end else begin
            stage[0] <= slice_fn(dsp_opmode, dsp_a, dsp_b, dsp_d, dsp_c, dsp_carryin);
            for (int i = 1; i < PIPE_LAT - 1; i++) stage[i] <= stage[i-1];
        end
    end
    assign dsp_p        = stage[PIPE_LAT-2][47:0];
    assign dsp_carryout = stage[PIPE_LAT-2][48];

    typedef struct {
        logic [48:0] res;
        int          avail;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   total = 0, bad = 0;
    bit   chk_rdy = 1'b0;
    int   nacc, npop, first_pop, last_pop, nflush, flush_cyc, nmis;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: sample and score just after the falling edge, then advance.
    task automatic tick();
        bit exp_valid;
        #1;
        exp_valid = 1'b0;
        if (sbq.size() > 0) exp_valid = (sbq[0].avail <= cyc);
        if (chk_rdy) check("cmd_ready", cmd_ready, (sbq.size() < FIFO_DEPTH) && !flush);
        check("res_valid", res_valid, exp_valid);
        check("busy", busy, sbq.size() > 0);
        if (flush_done) begin
            nflush++;
            flush_cyc = cyc;
        end
`ifdef DSP_SEQ_CHECK_EN
        if (mismatch) nmis++;
`endif
        if (res_valid && res_ready && sbq.size() > 0) begin
            check("res_data", {res_carryout, res_p}, sbq[0].res);
            void'(sbq.pop_front());
            npop++;
            if (npop == 1) first_pop = cyc;
            last_pop = cyc;
        end
        if (cmd_valid && cmd_ready) begin
            sbq.push_back('{res: slice_fn(cmd_opmode, cmd_a, cmd_b, cmd_d, cmd_c, cmd_carryin),
                            avail: cyc + 1 + PIPE_LAT});
            nacc++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_cmd();
        cmd_opmode  = {1'b0, 1'($urandom), 1'b0, 1'($urandom),
                       ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0,
                       ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd1};
        cmd_a       = 18'($urandom);
        cmd_b       = 18'($urandom);
        cmd_d       = 18'($urandom);
        cmd_c       = {16'($urandom), 32'($urandom)};
        cmd_carryin = 1'($urandom);
    endtask

    // Called on a falling edge: asserts reset, checks the reset values,
    // releases it and measures how long dsp_rst stays high.
    task automatic do_reset();
        int n;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        flush     = 1'b0;
        sbq.delete();
        #1;
        check("reset_ctrl", {cmd_ready, flush_done, res_valid, busy, dsp_rst, dsp_ce}, 6'b000011);
        check("reset_dsp_abd", {dsp_a, dsp_b, dsp_d}, '0);
        check("reset_dsp_c", dsp_c, '0);
        check("reset_dsp_op", {dsp_opmode, dsp_carryin}, '0);
        check("reset_res", {res_carryout, res_p}, '0);
`ifdef DSP_SEQ_CHECK_EN
        check("reset_err", {mismatch, err_cnt}, '0);
`endif
        @(negedge clk);
        rst_n     = 1'b1;
        cmd_valid = 1'b1;          // must not be taken while INIT holds the slice in reset
        rand_cmd();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!dsp_rst) break;
            check("init_cmd_ready", cmd_ready, 1'b0);
            n++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("dsp_rst_cycles", n, RST_CYC);
        check("init_no_issue", {dsp_a, dsp_b}, '0);
        @(negedge clk);
    endtask

    initial begin
        int n;
        int exp_done;
`ifdef DSP_SEQ_CHECK_EN
        logic [48:0] r;
`endif
        @(negedge clk);
        do_reset();

        // Concatenation: {D[11:0], A, B} with A=B=D=1.
        chk_rdy     = 1'b1;
        cmd_opmode  = 8'h03;
        cmd_a       = 18'd1;
        cmd_b       = 18'd1;
        cmd_d       = 18'd1;
        cmd_c       = '0;
        cmd_carryin = 1'b0;
        cmd_valid   = 1'b1;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 20) begin
            tick();
            n++;
        end
        check("concat_latency", n, PIPE_LAT);
        check("concat_p", res_p, 48'h1000040001);
        check("concat_co", res_carryout, 1'b0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Throughput: eight back-to-back commands, results one per cycle.
        res_ready = 1'b1;
        npop = 0;
        nacc = 0;
        for (int i = 0; i < 8; i++) begin
            rand_cmd();
            cmd_valid = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        check("thru_accepts", nacc, 8);
        for (int i = 0; i < 40 && npop < 8; i++) tick();
        check("thru_count", npop, 8);
        check("thru_span", last_pop - first_pop, 7);

        // Backpressure: nothing popped, commands keep coming.
        res_ready = 1'b0;
        nacc = 0;
        for (int i = 0; i < 3 * FIFO_DEPTH; i++) begin
            rand_cmd();
            cmd_valid = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        check("bp_accepts", nacc, FIFO_DEPTH);
        check("bp_ready_low", cmd_ready, 1'b0);
        res_ready = 1'b1;
        npop = 0;
        for (int i = 0; i < 40 && npop < FIFO_DEPTH; i++) tick();
        check("bp_drained", npop, FIFO_DEPTH);
        res_ready = 1'b0;

        // Flush with three commands in flight; results stay in the FIFO.
        for (int i = 0; i < 3; i++) begin
            rand_cmd();
            cmd_valid = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        exp_done  = sbq[$].avail + 1;
        flush     = 1'b1;
        cmd_valid = 1'b1;          // offered but must be refused while flushing
        nflush    = 0;
        flush_cyc = -1;
        for (int i = 0; i < 16; i++) tick();
        cmd_valid = 1'b0;
        check("flush_pulses", nflush, 1);
        check("flush_cycle", flush_cyc, exp_done);
        check("flush_busy", busy, 1'b1);
        flush   = 1'b0;
        chk_rdy = 1'b0;            // DRAIN still refuses for the cycle flush drops
        tick();
        chk_rdy   = 1'b1;
        res_ready = 1'b1;
        npop = 0;
        for (int i = 0; i < 20 && npop < 3; i++) tick();
        check("flush_popped", npop, 3);
        check("flush_idle", busy, 1'b0);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 300; i++) begin
            rand_cmd();
            cmd_valid = ($urandom_range(0, 3) != 0);
            res_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        res_ready = 1'b0;
        rand_cmd();
        cmd_valid = 1'b1;
        tick();
        tick();
        check("pre_reset_busy", busy, 1'b1);

        // Reset in the middle of traffic discards everything.
        chk_rdy = 1'b0;
        do_reset();
        chk_rdy = 1'b1;

`ifdef DSP_SEQ_CHECK_EN
        // Four checked commands, the third carrying a wrong expectation.
        res_ready = 1'b1;
        nmis = 0;
        for (int i = 0; i < 4; i++) begin
            rand_cmd();
            r         = slice_fn(cmd_opmode, cmd_a, cmd_b, cmd_d, cmd_c, cmd_carryin);
            cmd_exp   = r[47:0] ^ ((i == 2) ? 48'h1 : 48'h0);
            cmd_chk   = 1'b1;
            cmd_valid = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        cmd_chk   = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("mismatch_pulses", nmis, 1);
        check("err_cnt", err_cnt, 16'd1);
`endif

        // Traffic after reset still flows.
        res_ready = 1'b1;
        npop = 0;
        rand_cmd();
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 20 && npop < 1; i++) tick();
        check("post_reset_result", npop, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dsp_cmd_sequencer.md
Name: dsp_cmd_sequencer

Overview:
- Initiator-side driver for the DSP48A1 slice (`dsp`).
- Accepts operand/OPMODE commands on a valid/ready stream and drives them into the slice, one per cycle.
- Tracks the slice's fixed pipeline latency and captures P/CARRYOUT into a small result FIFO with valid/ready output.
- Replaces hand-timed stimulus: results come back in issue order with backpressure.

Parameters:
- PIPE_LAT, 4, cycles from dsp input sample to valid P (all slice registers enabled); legal range 1..8.
- FIFO_DEPTH, 4, result FIFO entries; power of two, ≥ 2.
- RST_CYC, 2, cycles dsp_rst is held after RST_N deasserts; ≥ 1.

Ports:
- CLK in 1: clock, rising edge.
- RST_N in 1: asynchronous active-low reset.
- cmd_valid in 1: command present.
- cmd_ready out 1: command accepted when valid&ready.
- cmd_opmode in 8: OPMODE for the slice.
- cmd_a, cmd_b, cmd_d in 18 each: operands.
- cmd_c in 48: operand.
- cmd_carryin in 1: CARRYIN.
- flush in 1: level request to drain the pipeline.
- flush_done out 1: one-cycle pulse when drain completes.
- dsp_a, dsp_b, dsp_d out 18; dsp_c out 48; dsp_opmode out 8; dsp_carryin out 1: slice inputs.
- dsp_rst out 1: active-high, tied to all slice RST* pins.
- dsp_ce out 1: tied to all slice CE* pins.
- dsp_p in 48; dsp_carryout in 1: slice outputs.
- res_valid out 1, res_ready in 1, res_p out 48, res_carryout out 1: result stream.
- busy out 1: in-flight or FIFO non-empty.

Behaviour:
- Reset (RST_N=0, async), all outputs:
  - cmd_ready=0, flush_done=0, res_valid=0, busy=0.
  - dsp_rst=1, dsp_ce=1.
  - All dsp_* data and dsp_opmode = 0; res_p=0, res_carryout=0.
  - FIFO and credit state cleared.
- FSM states INIT, RUN, DRAIN.
  - INIT: dsp_rst=1 for RST_CYC cycles after RST_N rises, then → RUN.
  - RUN: cmd_ready = (credits>0) && !flush. On flush → DRAIN.
  - DRAIN: cmd_ready=0. When in-flight count = 0: pulse flush_done, → RUN if flush is low, else stay in DRAIN with no further pulse until flush drops.
- Issue:
  - On accept, register all cmd_* fields onto dsp_* on the same edge.
  - Push 1 into valid shift register vld[PIPE_LAT-1:0].
  - Cycles with no accept hold the previous dsp_* values and push 0.
- Capture: when vld[PIPE_LAT-1]=1, write {dsp_p, dsp_carryout} into the FIFO on that edge. Latency is PIPE_LAT+1 cycles from accept to earliest res_valid.
- Credits:
  - credits = FIFO_DEPTH − fifo_count − inflight.
  - Accept requires credits ≥ 1, so the FIFO never overflows and the slice never needs stalling; dsp_ce stays 1.
  - Same-cycle accept and pop: credit count is net unchanged.
- FIFO outputs:
  - res_valid = !empty; head entry is on res_p/res_carryout.
  - Pop on res_valid&res_ready.
  - Full and empty pointers wrap modulo FIFO_DEPTH using an extra MSB.
- Simultaneous push and pop when full is impossible by credit rule. When empty, a push is visible the next cycle (no bypass).
- RST_N asserted mid-operation: in-flight results and FIFO contents are discarded and the FSM re-enters INIT.
- busy = (inflight≠0) || !empty.

Optional Feature:
- Macro DSP_SEQ_CHECK_EN.
- With it defined:
  - Extra inputs cmd_exp (48) and cmd_chk (1) travel alongside vld.
  - On capture with chk=1 and dsp_p≠exp, mismatch pulses for one cycle.
  - err_cnt (16, saturating) increments; cleared only by reset.
- Without it: those ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package dsp_seq_pkg:
  - FSM state enum {INIT, RUN, DRAIN}.
  - Widths A_W=18, C_W=48, OP_W=8.
  - Result struct {p, carryout}.
- Sub-module dsp_seq_fifo: sync FIFO, parameterised width/depth, with count output.

Test Plan:
- Reset: RST_N low mid-stream → all outputs at reset values immediately; dsp_rst high for exactly RST_CYC cycles after release; cmd_ready=0 during INIT.
- Concat op:
  - Stimulus: OPMODE=0x03, A=1, B=1, D=1, C=0, CARRYIN=0.
  - Required: res_p=0x1000040001 at accept+PIPE_LAT+1.
- Throughput: 8 back-to-back commands with res_ready=1 → 8 results, in order, one per cycle, no bubbles after the first.
- Backpressure:
  - Stimulus: res_ready=0 while commands keep arriving.
  - Required: cmd_ready drops after exactly FIFO_DEPTH accepts and no entry is lost.
  - Then res_ready=1 → all FIFO_DEPTH results drain in order.
- Flush:
  - Stimulus: assert flush with 3 commands in flight.
  - Required: cmd_ready=0; flush_done pulses once, the cycle after the last capture; busy stays 1 until the FIFO is popped.
- With DSP_SEQ_CHECK_EN:
  - Stimulus: cmd_exp deliberately wrong on one of four commands.
  - Required: exactly one mismatch pulse; err_cnt=1.
